mux_arbiter_2to1: RTL and testbench
===================================

MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive grant cycles per requester (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have ports req_a and req_b, input, 1 each, the access requests from requesters A and B.
REQ-005 The block SHALL have ports din_a and din_b, input, 1 each, the data bits from requesters A and B.
REQ-006 The block SHALL have ports gnt_a and gnt_b, output, 1 each, the registered grants.
REQ-007 The block SHALL have port sel, output, 1, the registered mux select: 0 selects din_a, 1 selects din_b.
REQ-008 The block SHALL have port dout, output, 1, the shared mux output.
REQ-009 The block SHALL have port dout_valid, output, 1, high when dout carries granted, requested data.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT_A and GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B, and never both.
REQ-011 In IDLE, with only one request high, the FSM SHALL enter that requester's GRANT state on the next edge, giving a request-to-grant latency of exactly 1 cycle.
REQ-012 In IDLE with both requests high, the FSM SHALL grant the requester opposite to the last_served register (round-robin).
REQ-013 On entering a GRANT state the FSM SHALL set last_served to that requester, clear hold_cnt to 0, and set sel to 0 for A or 1 for B in the same edge.
REQ-014 hold_cnt SHALL increment by 1 each cycle the FSM stays in a GRANT state with that state's request high; its width is clog2(HOLD_MAX)+1 and it never wraps.
REQ-015 The FSM SHALL release a grant when the owner's request is low, or when hold_cnt equals HOLD_MAX-1 with the request high, so that at most HOLD_MAX granted cycles occur.
REQ-016 On release with the other request high, the FSM SHALL move directly to the other GRANT state with no IDLE bubble.
REQ-017 On release due to hold expiry with the other request low and the owner's request high, the FSM SHALL stay in the same GRANT state and clear hold_cnt to 0.
REQ-018 On release with both requests low, the FSM SHALL enter IDLE; in IDLE, sel SHALL hold its last value.
REQ-019 dout SHALL equal sel ? din_b : din_a combinationally, with no added latency.
REQ-020 dout_valid SHALL equal (gnt_a & req_a) | (gnt_b & req_b) combinationally.
REQ-021 A request that drops and reasserts in the same cycle as its release SHALL be treated as low for that release decision.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL set state=IDLE, gnt_a=0, gnt_b=0, sel=0, hold_cnt=0 and last_served=B, so that A wins the first tie.
REQ-023 Reset asserted mid-grant SHALL take priority over every transition; the first grant after reset SHALL follow REQ-011/REQ-012.

Structure
REQ-024 The state encoding (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) SHALL be defined in a shared package, mux_arb_pkg.
REQ-025 The selector datapath SHALL be one instance of the existing 1-bit mux sub-module, mux_1bit, with ports (A=din_a, B=din_b, X=sel, Y=dout).
REQ-026 All state, grants, sel, hold_cnt and last_served SHALL be registered; dout and dout_valid SHALL be the only combinational outputs.

Verification
REQ-027 The bench SHALL check reset: hold rst=1 for 2 cycles with req_a=req_b=1, then release; gnt_a, gnt_b and sel are 0 during reset, and gnt_a=1 exactly 1 cycle after rst falls.
REQ-028 The bench SHALL check a single requester: req_a=1, din_a toggling 0/1, req_b=0, HOLD_MAX=4; gnt_a stays high continuously, hold_cnt cycles 0..3, dout tracks din_a and dout_valid=1.
REQ-029 The bench SHALL check contention: req_a=req_b=1 held, HOLD_MAX=4; the grant alternates A,A,A,A,B,B,B,B,A..., sel tracks the grant, and there are no IDLE cycles.
REQ-030 The bench SHALL check early release: req_b drops after 2 granted cycles while req_a=1; gnt_a=1 on the next edge and sel=0.
REQ-031 The bench SHALL check the return to IDLE: both requests drop; gnt_a=gnt_b=0, dout_valid=0, and sel holds its last value.
REQ-032 The bench SHALL check reset mid-grant: rst=1 while in GRANT_B with hold_cnt=2; the next state is IDLE, and with both requests high after reset, A is granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding for the 2:1 mux arbiter
package mux_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;
endpackage

// File: rtl/mux_1bit.sv
// mux_1bit: single-bit 2:1 selector, Y = X ? B : A
module mux_1bit (
  input  logic A,
  input  logic B,
  input  logic X,
  output logic Y
);
  assign Y = X ? B : A;
endmodule

// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: round-robin two-requester arbiter with hold limit driving a shared 1-bit mux
module mux_arbiter_2to1
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic din_a,
  input  logic din_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic dout,
  output logic dout_valid
);
  localparam int W = $clog2(HOLD_MAX) + 1;
  localparam logic [W-1:0] LAST = W'(HOLD_MAX - 1);
  state_t state, nxt_state;
  logic last_served;
  logic [W-1:0] hold_cnt, nxt_cnt;
  logic expire, rel_a, rel_b;
  assign expire = hold_cnt == LAST;
  always_comb begin
    rel_a = !req_a || expire;
    rel_b = !req_b || expire;
    case (state)
      IDLE:    nxt_state = (req_a && req_b) ? (last_served ? GRANT_A : GRANT_B) :
                           req_a ? GRANT_A : req_b ? GRANT_B : IDLE;
      GRANT_A: nxt_state = !rel_a ? GRANT_A : req_b ? GRANT_B : req_a ? GRANT_A : IDLE;
      GRANT_B: nxt_state = !rel_b ? GRANT_B : req_a ? GRANT_A : req_b ? GRANT_B : IDLE;
      default: nxt_state = IDLE;
    endcase
    nxt_cnt = (nxt_state == state && state != IDLE && !expire) ? hold_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sel         <= 1'b0;
      hold_cnt    <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= nxt_state;
      gnt_a       <= nxt_state == GRANT_A;
      gnt_b       <= nxt_state == GRANT_B;
      sel         <= nxt_state == GRANT_B ? 1'b1 : nxt_state == GRANT_A ? 1'b0 : sel;
      hold_cnt    <= nxt_cnt;
      last_served <= nxt_state == GRANT_B ? 1'b1 : nxt_state == GRANT_A ? 1'b0 : last_served;
    end
  end
  mux_1bit u_mux (
    .A(din_a),
    .B(din_b),
    .X(sel),
    .Y(dout)
  );
  assign dout_valid = (gnt_a & req_a) | (gnt_b & req_b);
endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// tb_mux_arbiter_2to1: directed self-checking bench for mux_arbiter_2to1 with HOLD_MAX=4
module tb_mux_arbiter_2to1;
  logic clk = 1'b0;
  logic rst, req_a, req_b, din_a, din_b;
  logic gnt_a, gnt_b, sel, dout, dout_valid;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mux_arbiter_2to1 #(.HOLD_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .req_b(req_b),
    .din_a(din_a),
    .din_b(din_b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .sel(sel),
    .dout(dout),
    .dout_valid(dout_valid)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] pat;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; din_a = 1'b0; din_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt_a", gnt_a, 0);
      chk("rst_gnt_b", gnt_b, 0);
      chk("rst_sel", sel, 0);
      chk("rst_cnt", dut.hold_cnt, 0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_gnt_a", gnt_a, 1);
    chk("post_rst_gnt_b", gnt_b, 0);
    chk("post_rst_sel", sel, 0);
    pat = 8'b0111_1000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cont_gnt_b", gnt_b, pat[i]);
      chk("cont_gnt_a", gnt_a, !pat[i]);
      chk("cont_sel", sel, pat[i]);
    end
    for (int i = 0; i < 5; i++) step();
    chk("pre_early_gnt_b", gnt_b, 1);
    chk("pre_early_cnt", dut.hold_cnt, 1);
    req_b = 1'b0;
    #1;
    chk("early_valid_drop", dout_valid, 0);
    step();
    chk("early_gnt_a", gnt_a, 1);
    chk("early_gnt_b", gnt_b, 0);
    chk("early_sel", sel, 0);
    chk("early_cnt", dut.hold_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      din_a = i[0];
      din_b = !i[0];
      #1;
      chk("single_dout", dout, i[0]);
      chk("single_valid", dout_valid, 1);
      step();
      chk("single_gnt_a", gnt_a, 1);
      chk("single_gnt_b", gnt_b, 0);
      chk("single_cnt", dut.hold_cnt, (i + 1) % 4);
    end
    req_a = 1'b0; req_b = 1'b1;
    step();
    chk("handoff_gnt_b", gnt_b, 1);
    chk("handoff_sel", sel, 1);
    step();
    req_b = 1'b0; din_a = 1'b0; din_b = 1'b1;
    #1;
    chk("drop_valid", dout_valid, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_gnt_a", gnt_a, 0);
      chk("idle_gnt_b", gnt_b, 0);
      chk("idle_sel_hold", sel, 1);
      chk("idle_dout", dout, 1);
      chk("idle_valid", dout_valid, 0);
    end
    req_b = 1'b1;
    step();
    chk("b_latency", gnt_b, 1);
    step();
    step();
    chk("mid_cnt", dut.hold_cnt, 2);
    req_a = 1'b1; rst = 1'b1;
    step();
    chk("mid_rst_state", 8'(dut.state), 0);
    chk("mid_rst_gnt_b", gnt_b, 0);
    chk("mid_rst_sel", sel, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_first_a", gnt_a, 1);
    chk("mid_rst_first_b", gnt_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
